// File: rtl/muldiv_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : muldiv_sequencer_pkg
// Brief  : Op codes, FSM state encoding and helpers for the HI/LO mul/div unit
// Rev    : 1.0  initial release
// ============================================================================
package muldiv_sequencer_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Multi-cycle ops occupy the lower half of the op space.
    function automatic logic is_iterative(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module : muldiv_step
// Brief  : One radix-2 iteration: shift-add multiply or restoring divide
// Rev    : 1.0  initial release
// ============================================================================
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] aux,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] aux_nxt
);

    logic [WIDTH:0] w_add;
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_diff;

    always_comb begin
        w_add    = aux[0] ? ({1'b0, acc} + {1'b0, operand}) : {1'b0, acc};
        w_rem_sh = {acc, aux[WIDTH-1]};
        w_diff   = w_rem_sh - {1'b0, operand};
        acc_nxt  = '0;
        aux_nxt  = '0;
        if (is_div) begin
            // Bit WIDTH of the difference is the borrow of the trial subtract.
            if (!w_diff[WIDTH]) begin
                acc_nxt = w_diff[WIDTH-1:0];
                aux_nxt = {aux[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = w_rem_sh[WIDTH-1:0];
                aux_nxt = {aux[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nxt = w_add[WIDTH:1];
            aux_nxt = {w_add[0], aux[WIDTH-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module : muldiv_sequencer
// Brief  : Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning architectural HI/LO
// Rev    : 1.0  initial release
// ============================================================================
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             hilo_rd,
    output logic             ready,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic               r_is_div;
    logic               r_signed;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_op1;
    logic [WIDTH-1:0]   r_op2;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_aux;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_dbz;

    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_aux_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_hi_fix;
    logic [WIDTH-1:0]   w_lo_fix;
    logic               w_dbz;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (r_is_div),
        .acc     (r_acc),
        .aux     (r_aux),
        .operand (r_opnd),
        .acc_nxt (w_acc_nxt),
        .aux_nxt (w_aux_nxt)
    );

    always_comb begin
        w_abs1   = (r_signed && r_op1[WIDTH-1]) ? -r_op1 : r_op1;
        w_abs2   = (r_signed && r_op2[WIDTH-1]) ? -r_op2 : r_op2;
        w_prod   = r_neg_q ? -{r_acc, r_aux} : {r_acc, r_aux};
        w_dbz    = r_is_div && (r_op2 == '0);
        w_hi_fix = w_prod[2*WIDTH-1:WIDTH];
        w_lo_fix = w_prod[WIDTH-1:0];
        // Divide by zero still runs full length, then reports the raw dividend.
        if (w_dbz) begin
            w_hi_fix = r_op1;
            w_lo_fix = '1;
        end else if (r_is_div) begin
            w_hi_fix = r_neg_r ? -r_acc : r_acc;
            w_lo_fix = r_neg_q ? -r_aux : r_aux;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_is_div <= 1'b0;
            r_signed <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_aux    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (md_op == MD_MTHI) begin
                            r_hi <= operand1;
                        end else if (md_op == MD_MTLO) begin
                            r_lo <= operand1;
                        end else if (is_iterative(md_op)) begin
                            r_is_div <= md_op[1];
                            r_signed <= ~md_op[0];
                            r_op1    <= operand1;
                            r_op2    <= operand2;
                            r_state  <= S_PREP;
                        end
                    end
                end
                S_PREP: begin
                    r_neg_q <= r_signed & (r_op1[WIDTH-1] ^ r_op2[WIDTH-1]);
                    r_neg_r <= r_signed & r_op1[WIDTH-1];
                    r_opnd  <= w_abs2;
                    r_aux   <= w_abs1;
                    r_acc   <= '0;
                    r_count <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    r_acc   <= w_acc_nxt;
                    r_aux   <= w_aux_nxt;
                    r_count <= r_count + 1'b1;
                    if (r_count == CNT_W'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_hi    <= w_hi_fix;
                    r_lo    <= w_lo_fix;
                    r_done  <= 1'b1;
                    r_dbz   <= w_dbz;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready       = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign stall       = busy & (hilo_rd | start);
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule
`default_nettype wire
